// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, ROM port and IF/ID register outputs.
// master = fetch stage, slave = the surrounding pipeline / ROM.
interface fetch_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      rom_addr;
  logic [31:0]      rom_inst;
  logic [31:0]      if_id_inst;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    input  stall, redirect, redirect_pc, rom_inst,
    output rom_addr, if_id_inst, if_id_pc4, if_id_valid, fetch_cnt
  );

  modport slave (
    output stall, redirect, redirect_pc, rom_inst,
    input  rom_addr, if_id_inst, if_id_pc4, if_id_valid, fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and fills IF/ID.
// Priority each cycle: rst > redirect > stall > normal fetch.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-state selection; a stall simply keeps the defaults.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.redirect) begin
      pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      inst_d  = NOP_INST;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d    = pc_plus4;
      inst_d  = bus.rom_inst;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_RESET;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // rom_addr depends on the PC register only, never on stall/redirect.
  assign bus.rom_addr    = {pc_q[XLEN-1:2], 2'b00};
  assign bus.if_id_inst  = inst_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_cnt   = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-cycle vectors plus reset and
// counter-saturation sequences on a second, narrow-counter instance.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.CNT_W(16)) bus1 ();
  fetch_stage_if #(.CNT_W(3))  bus2 ();

  // Main ROM model: word i = A000_0000 + i, decoded on a[7:2].
  assign bus1.rom_inst = 32'hA000_0000 + {26'd0, bus1.rom_addr[7:2]};
  // Second ROM returns only NOP words, which still count as real fetches.
  assign bus2.rom_inst = 32'h0000_0000;

  fetch_stage #(.PC_RESET(32'h0), .NOP_INST(32'h0), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  fetch_stage #(.PC_RESET(32'h0), .NOP_INST(32'h0), .CNT_W(3)) dut_sat (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                      input logic [31:0] pc4, input logic valid, input logic [15:0] cnt);
    chk({tag, " rom_addr"},    bus1.rom_addr,           addr);
    chk({tag, " if_id_inst"},  bus1.if_id_inst,         inst);
    chk({tag, " if_id_pc4"},   bus1.if_id_pc4,          pc4);
    chk({tag, " if_id_valid"}, 32'(bus1.if_id_valid),   32'(valid));
    chk({tag, " fetch_cnt"},   32'(bus1.fetch_cnt),     32'(cnt));
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic [31:0] a, input logic [31:0] i,
                              input logic [31:0] p4, input logic v, input logic [15:0] c);
    vec_t t;
    t.stall = s; t.redirect = r; t.redirect_pc = rpc;
    t.exp_addr = a; t.exp_inst = i; t.exp_pc4 = p4; t.exp_valid = v; t.exp_cnt = c;
    return t;
  endfunction

  initial begin
    //                 stall redir rpc            addr           inst           pc4            v     cnt
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,          32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1'b1, 16'd1);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,          32'h0000_0008, 32'hA000_0001, 32'h0000_0008, 1'b1, 16'd2);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,          32'h0000_0008, 32'hA000_0001, 32'h0000_0008, 1'b1, 16'd2);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,          32'h0000_0008, 32'hA000_0001, 32'h0000_0008, 1'b1, 16'd2);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,          32'h0000_000C, 32'hA000_0002, 32'h0000_000C, 1'b1, 16'd3);
    vecs[5]  = mk(1'b0, 1'b1, 32'h0000_0023,  32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd3);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,          32'h0000_0024, 32'hA000_0008, 32'h0000_0024, 1'b1, 16'd4);
    vecs[7]  = mk(1'b1, 1'b1, 32'h0000_0004,  32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd4);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,          32'h0000_0008, 32'hA000_0001, 32'h0000_0008, 1'b1, 16'd5);
    vecs[9]  = mk(1'b0, 1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd5);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,          32'h0000_0000, 32'hA000_003F, 32'h0000_0000, 1'b1, 16'd6);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,          32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1'b1, 16'd7);
    vecs[12] = mk(1'b0, 1'b1, 32'h0000_0100,  32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd7);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,          32'h0000_0104, 32'hA000_0000, 32'h0000_0104, 1'b1, 16'd8);
    vecs[14] = mk(1'b0, 1'b1, 32'h0000_0010,  32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd8);
    vecs[15] = mk(1'b1, 1'b0, 32'h0,          32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd8);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,          32'h0000_0014, 32'hA000_0004, 32'h0000_0014, 1'b1, 16'd9);

    rst  = 1'b1;
    rst2 = 1'b1;
    bus1.stall = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = 32'h0;
    bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk1("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      bus1.stall       = vecs[i].stall;
      bus1.redirect    = vecs[i].redirect;
      bus1.redirect_pc = vecs[i].redirect_pc;
      @(posedge clk);
      #1;
      chk1($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_inst,
           vecs[i].exp_pc4, vecs[i].exp_valid, vecs[i].exp_cnt);
    end

    // Reset mid-operation wins over a simultaneous redirect and clears everything.
    bus1.stall = 1'b0; bus1.redirect = 1'b1; bus1.redirect_pc = 32'h0000_0040;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("midreset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    rst = 1'b0; bus1.redirect = 1'b0;
    @(posedge clk);
    #1;
    chk1("after_midreset", 32'h4, 32'hA000_0000, 32'h4, 1'b1, 16'd1);

    // Narrow counter: NOP words count, and the count sticks at all-ones.
    #1;
    chk("sat reset cnt", 32'(bus2.fetch_cnt), 32'd0);
    rst2 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat cnt%0d", i), 32'(bus2.fetch_cnt), (i > 7) ? 32'd7 : 32'(i));
    end
    chk("sat valid", 32'(bus2.if_id_valid), 32'd1);
    chk("sat inst",  bus2.if_id_inst, 32'h0);
    chk("sat addr",  bus2.rom_addr, 32'h0000_0024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
